// File: rtl/bcd_seg7_scanner_pkg.sv
// Shared constants and helpers for the BCD seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_seg7_scanner_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic logic has_invalid(input logic [15:0] v);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/bcd_seg7_scanner_if.sv
// Value/strobe input and display pin bundle for the scanner.
// master drives the BCD value, slave drives the display.
interface bcd_seg7_scanner_if;

    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        digit_err;

    modport master (
        output bcd_in, bcd_valid, dp_in,
        input  an, seg, dp, digit_err
    );

    modport slave (
        input  bcd_in, bcd_valid, dp_in,
        output an, seg, dp, digit_err
    );

endinterface

// File: rtl/bcd_seg7_scanner_seg.sv
// Combinational BCD nibble to active-low seven-segment code.
// Non-decimal nibbles render as a dash.
module bcd_to_seg7
    import bcd_seg7_scanner_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_DASH;
        case (nib)
            4'd0: code = SEG_0;
            4'd1: code = SEG_1;
            4'd2: code = SEG_2;
            4'd3: code = SEG_3;
            4'd4: code = SEG_4;
            4'd5: code = SEG_5;
            4'd6: code = SEG_6;
            4'd7: code = SEG_7;
            4'd8: code = SEG_8;
            4'd9: code = SEG_9;
            default: code = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Four-digit multiplexed common-anode display driver with
// ghost blanking, leading-zero blanking and invalid-digit flag.
module bcd_seg7_scanner
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic clk,
    input  logic rst_n,
    bcd_seg7_scanner_if.slave bus
);

    localparam int CW = cnt_width(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]           cnt;
    logic [1:0]              idx;
    logic [15:0]             held;
    logic [NUM_DIGITS-1:0]   lit;
    logic [3:0]              nib;
    logic [6:0]              seg_code;
    logic [3:0]              an_sel;
    logic                    drive;

    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;
    logic       err_q;

    // Invalid nibbles are non-zero, so they keep lower digits lit.
    always_comb begin
        lit    = '1;
        if (LZ_BLANK != 0) begin
            lit[3] = (held[15:12] != 4'd0);
            lit[2] = (held[15:8]  != 8'd0);
            lit[1] = (held[15:4]  != 12'd0);
        end
    end

    always_comb begin
        nib    = 4'(held >> {idx, 2'b00});
        an_sel = ~(4'b0001 << idx);
        drive  = (cnt >= CNT_BLANK) && lit[idx];
    end

    bcd_to_seg7 u_dec (
        .nib  (nib),
        .code (seg_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            held  <= '0;
            an_q  <= 4'hF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            if (bus.bcd_valid) begin
                held  <= bus.bcd_in;
                err_q <= has_invalid(bus.bcd_in);
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (drive) begin
                an_q  <= an_sel;
                seg_q <= seg_code;
                dp_q  <= ~bus.dp_in[idx];
            end else begin
                an_q  <= 4'hF;
                seg_q <= SEG_OFF;
                dp_q  <= 1'b1;
            end
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_err = err_q;

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Downstream consumer of the 12-bit binary-to-BCD converter.
- Captures the 4-digit packed BCD result on the converter's one-cycle done strobe.
- Drives a 4-digit common-anode multiplexed seven-segment display with time-division scanning.
- Also provides ghost-suppression blanking, leading-zero blanking and invalid-digit flagging.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range is 4 or more.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- LZ_BLANK, 1: 1 enables leading-zero blanking; 0 shows all four digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  16  packed BCD; [15:12] thousands, [3:0] units.
- bcd_valid  input  1  one-cycle strobe; bcd_in is sampled on the same edge.
- dp_in  input  4  per-digit decimal point request, active-high; sampled continuously.
- an  output  4  anode enables, active-low; an[0] = units.
- seg  output  7  segments, active-low, {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- digit_err  output  1  high while the held value contains a nibble greater than 9.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - an = 4'hF, seg = 7'h7F, dp = 1, digit_err = 0.
  - Held value = 16'h0000, slot counter = 0, digit index = 0.
- Capture:
  - On a clk edge with bcd_valid = 1, the held register loads bcd_in.
  - digit_err loads (any nibble > 9) on the same edge.
  - Capture never resets or stalls the scan; the new value appears on the outputs from the next output update.
  - bcd_valid held high for multiple cycles recaptures every cycle, which is harmless.
- Scan timing:
  - Slot counter runs 0 to REFRESH_DIV-1, then wraps to 0.
  - On wrap, the digit index advances 0, 1, 2, 3, 0.
- Slot phase:
  - Counter < BLANK_CYCLES: blank phase. an = 4'hF, seg = 7'h7F, dp = 1.
  - Otherwise: drive phase. an = ~(4'b0001 << index), seg = decode(nibble[index]), dp = ~dp_in[index].
- Output registers:
  - All outputs are registered, with one cycle of latency from counter, index or held-value state to pins.
  - Outputs never glitch within a cycle.
- Leading-zero blanking (LZ_BLANK = 1):
  - Digit 3 is suppressed if it is 0.
  - Digit 2 is suppressed if digits 3 and 2 are both 0.
  - Digit 1 is suppressed if digits 3, 2 and 1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its anode off for the whole slot, dp included.
  - Any invalid nibble in a higher position counts as non-zero, so lower digits are not suppressed.
- Decode (active-low gfedcba):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19.
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
  - 10 to 15 = dash 7'h3F (segment g only).
- Simultaneous capture and slot wrap: both take effect on the same edge. The next slot shows the new value for the new index.
- Reset released mid-slot: scanning restarts from index 0, counter 0, which begins with a blank phase.

Decomposition:
- Shared package:
  - Segment code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - NUM_DIGITS = 4.
  - Counter width = clog2(REFRESH_DIV).
- Sub-module bcd_to_seg7: combinational 4-bit nibble to 7-bit active-low code, using the dash rule above.
- Top level owns:
  - the prescaler,
  - the index counter,
  - the held register,
  - the blanking logic,
  - the output registers.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2):
- Reset: rst_n low mid-drive with an = 4'hE → an = 4'hF, seg = 7'h7F, dp = 1 with no clock edge; after release the first slot is index 0 with 2 blank cycles.
- Capture: bcd_valid pulse with bcd_in = 16'h1234, LZ_BLANK = 1 → slot sequence an = E/D/B/7 with seg = 7'h19, 7'h30, 7'h24, 7'h79; each slot is 6 drive cycles after 2 blank cycles.
- Leading zeros: bcd_in = 16'h0007, LZ_BLANK = 1 → only index 0 lights with seg = 7'h78; indices 1 to 3 keep an = 4'hF for the full slot. With LZ_BLANK = 0 the display shows 0007.
- Invalid digit: bcd_in = 16'h0A05 → digit_err = 1; digit 2 shows 7'h3F; digit 1 shows 7'h40 (not blanked); digit 3 is blanked. A following capture of 16'h0005 → digit_err = 0.
- Boundary: bcd_valid asserted on the slot-wrap edge from index 1 to index 2 with 16'h4095 → the index 2 slot shows 7'h40 immediately; the scan period is unchanged at 32 cycles.
- Decimal point: dp_in = 4'b0010 with value 16'h1234 → dp = 0 only during index 1 drive cycles, and 1 during blank phases.
